// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver states, nominal line timing at 100 MHz
// and small helpers used by both the transmit and receive sides.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ARM,
        GAP,
        HIGH,
        ERR
    } ws2812_state_e;

    localparam int T0H         = 40;
    localparam int T1H         = 80;
    localparam int T_BIT       = 125;
    localparam int T_RESET_CYC = 5000;

    function automatic int timer_width(input int t_max);
        return $clog2(t_max + 1);
    endfunction

    // Low portion of a nominal bit cell for the given bit value.
    function automatic int low_time(input logic b);
        return T_BIT - (b ? T1H : T0H);
    endfunction

endpackage

// File: rtl/ws2812_sync_edge.sv
// Two-flop synchronizer for an asynchronous line plus a registered copy
// for single-cycle rise/fall detection on the synchronized signal.
module ws2812_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign din_s = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 one-wire receiver: measures high pulse widths on the synchronized
// line, assembles 24-bit pixel words and reports frame boundaries.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int T_MIN_HIGH     = 20,
    parameter int T_THRESH       = 60,
    parameter int T_MAX_HIGH     = 100,
    parameter int T_RESET        = T_RESET_CYC,
    parameter int PX_COUNT_WIDTH = 6,
    parameter int BITS_PER_PIXEL = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel_data,
    output logic                      pixel_valid,
    output logic [PX_COUNT_WIDTH-1:0] pixel_index,
    output logic                      frame_done,
    output logic [PX_COUNT_WIDTH-1:0] frame_len,
    output logic                      err
);

    localparam int TW = timer_width(T_RESET);
    localparam int BW = $clog2(BITS_PER_PIXEL);

    logic din_s, rise, fall;

    ws2812_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    ws2812_state_e             state_q, state_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [PX_COUNT_WIDTH-1:0] px_cnt_q, px_cnt_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic [BITS_PER_PIXEL-1:0] pixel_data_q, pixel_data_d;
    logic                      pixel_valid_q, pixel_valid_d;
    logic [PX_COUNT_WIDTH-1:0] pixel_index_q, pixel_index_d;
    logic                      frame_done_q, frame_done_d;
    logic [PX_COUNT_WIDTH-1:0] frame_len_q, frame_len_d;
    logic                      err_q, err_d;

    logic [TW-1:0]             high_len;
    logic [BITS_PER_PIXEL-1:0] new_word;
    logic                      bit_val, quiet, gap_end;

    // On the falling-edge cycle the timer holds (high cycles - 1).
    always_comb begin
        high_len = timer_q + TW'(1);
        bit_val  = (high_len >= TW'(T_THRESH));
        new_word = {shift_q[BITS_PER_PIXEL-2:0], bit_val};
        quiet    = !din_s && !fall && (timer_q >= TW'(T_RESET - 1));
        gap_end  = !rise && (timer_q == TW'(T_RESET - 1));
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        bit_cnt_d     = bit_cnt_q;
        px_cnt_d      = px_cnt_q;
        shift_d       = shift_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        pixel_index_d = pixel_index_q;
        frame_done_d  = 1'b0;
        frame_len_d   = frame_len_q;
        err_d         = err_q;

        if (rise || fall) begin
            timer_d = '0;
        end else if (timer_q != TW'(T_RESET)) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            ARM, ERR: begin
                if (quiet) begin
                    state_d   = GAP;
                    bit_cnt_d = '0;
                    px_cnt_d  = '0;
                    shift_d   = '0;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (gap_end) begin
                    if (px_cnt_q != '0 || bit_cnt_q != '0) begin
                        frame_done_d = 1'b1;
                        frame_len_d  = px_cnt_q;
                    end
                    if (bit_cnt_q != '0) begin
                        err_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    px_cnt_d  = '0;
                    shift_d   = '0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = GAP;
                    if (high_len < TW'(T_MIN_HIGH)) begin
                        err_d = 1'b1;
                    end else if (high_len > TW'(T_MAX_HIGH)) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else if (bit_cnt_q == BW'(BITS_PER_PIXEL - 1)) begin
                        shift_d       = '0;
                        bit_cnt_d     = '0;
                        pixel_data_d  = new_word;
                        pixel_index_d = px_cnt_q;
                        pixel_valid_d = 1'b1;
                        if (&px_cnt_q) begin
                            err_d = 1'b1;
                        end else begin
                            px_cnt_d = px_cnt_q + PX_COUNT_WIDTH'(1);
                        end
                    end else begin
                        shift_d   = new_word;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (timer_q >= TW'(T_MAX_HIGH)) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARM;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            px_cnt_q      <= '0;
            shift_q       <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_index_q <= '0;
            frame_done_q  <= 1'b0;
            frame_len_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            px_cnt_q      <= px_cnt_d;
            shift_q       <= shift_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_index_q <= pixel_index_d;
            frame_done_q  <= frame_done_d;
            frame_len_q   <= frame_len_d;
            err_q         <= err_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_index = pixel_index_q;
    assign frame_done  = frame_done_q;
    assign frame_len   = frame_len_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: nominal-timing instance for the threshold and
// single-pixel cases, fast-timing instances for long frames and saturation.
module tb_ws2812_rx;
    import ws2812_pkg::*;

    localparam int TMIN_F = 4;
    localparam int THR_F  = 12;
    localparam int TMAX_F = 20;
    localparam int TRST_F = 300;
    localparam int GAP_F  = 400;

    logic clk;
    logic [2:0] rst_v;
    logic [2:0] din_v;
    logic [2:0][23:0] pd;
    logic [2:0] pv, fd, er;
    logic [5:0] pi0, pi1, fl0, fl1;
    logic [1:0] pi_sat, fl_sat;

    int checks = 0;
    int errors = 0;

    logic [29:0] pix_q [3][$];
    logic [5:0]  frm_q [3][$];

    ws2812_rx dut0 (
        .clk(clk), .rst(rst_v[0]), .din(din_v[0]),
        .pixel_data(pd[0]), .pixel_valid(pv[0]), .pixel_index(pi0),
        .frame_done(fd[0]), .frame_len(fl0), .err(er[0])
    );

    ws2812_rx #(
        .T_MIN_HIGH(TMIN_F), .T_THRESH(THR_F), .T_MAX_HIGH(TMAX_F), .T_RESET(TRST_F)
    ) dut1 (
        .clk(clk), .rst(rst_v[1]), .din(din_v[1]),
        .pixel_data(pd[1]), .pixel_valid(pv[1]), .pixel_index(pi1),
        .frame_done(fd[1]), .frame_len(fl1), .err(er[1])
    );

    ws2812_rx #(
        .T_MIN_HIGH(TMIN_F), .T_THRESH(THR_F), .T_MAX_HIGH(TMAX_F), .T_RESET(TRST_F),
        .PX_COUNT_WIDTH(2)
    ) dut2 (
        .clk(clk), .rst(rst_v[2]), .din(din_v[2]),
        .pixel_data(pd[2]), .pixel_valid(pv[2]), .pixel_index(pi_sat),
        .frame_done(fd[2]), .frame_len(fl_sat), .err(er[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] idx_of(input int k);
        case (k)
            0:       return pi0;
            1:       return pi1;
            default: return {4'b0, pi_sat};
        endcase
    endfunction

    function automatic logic [5:0] len_of(input int k);
        case (k)
            0:       return fl0;
            1:       return fl1;
            default: return {4'b0, fl_sat};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int k, input int hi, input int lo);
        din_v[k] = 1'b1;
        idle(hi);
        din_v[k] = 1'b0;
        idle(lo);
    endtask

    task automatic send_bit(input int k, input logic b);
        if (k == 0) pulse(0, b ? T1H : T0H, low_time(b));
        else        pulse(k, b ? 15 : 6, 4);
    endtask

    task automatic send_bits(input int k, input logic [23:0] w, input int msb, input int lsb);
        for (int i = msb; i >= lsb; i--) send_bit(k, w[i]);
    endtask

    task automatic expect_px(input int k, input logic [5:0] idx, input logic [23:0] w);
        pix_q[k].push_back({idx, w});
    endtask

    task automatic expect_frame(input int k, input logic [5:0] len);
        frm_q[k].push_back(len);
    endtask

    task automatic check_drained(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_px_pending"}, pix_q[k].size(), 0);
            check({tag, "_frm_pending"}, frm_q[k].size(), 0);
        end
    endtask

    // Every output pulse must match the head of that instance's queue;
    // a pulse with nothing queued compares against an unreachable marker.
    always @(negedge clk) begin : mon
        logic [30:0] pw;
        logic [6:0]  fw;
        for (int k = 0; k < 3; k++) begin
            if (pv[k]) begin
                pw = (pix_q[k].size() > 0) ? {1'b0, pix_q[k].pop_front()} : 31'h4000_0000;
                check($sformatf("pixel%0d", k), {1'b0, idx_of(k), pd[k]}, pw);
            end
            if (fd[k]) begin
                fw = (frm_q[k].size() > 0) ? {1'b0, frm_q[k].pop_front()} : 7'h40;
                check($sformatf("frame%0d", k), {1'b0, len_of(k)}, fw);
            end
        end
    end

    initial begin
        logic [23:0] w;
        rst_v = 3'b111;
        din_v = 3'b000;
        idle(5);
        check("rst_pixel_data", pd[0], 0);
        check("rst_pixel_valid", pv[0], 0);
        check("rst_pixel_index", pi0, 0);
        check("rst_frame_done", fd[0], 0);
        check("rst_frame_len", fl0, 0);
        check("rst_err", er, 0);
        rst_v = 3'b000;

        // single pixel at nominal timing
        idle(6000);
        expect_px(0, 0, 24'hA5C33C);
        send_bits(0, 24'hA5C33C, 23, 0);
        check("single_err_mid", er[0], 0);
        expect_frame(0, 1);
        idle(6000);
        check("single_err", er[0], 0);
        check_drained("single");

        // high times 59 / 60 / 100 are the last three bits: 0, 1, 1
        w = 24'h123456;
        expect_px(0, 0, 24'h123453);
        send_bits(0, w, 23, 3);
        pulse(0, 59, 66);
        pulse(0, 60, 65);
        pulse(0, 100, 25);
        check("thresh_err_clean", er[0], 0);
        check("thresh_px_pending", pix_q[0].size(), 0);
        pulse(0, 101, 10);
        check("thresh_err_101", er[0], 1);
        idle(6000);
        check("thresh_no_frame", frm_q[0].size(), 0);
        expect_px(0, 0, 24'h5A5A5A);
        send_bits(0, 24'h5A5A5A, 23, 0);
        expect_frame(0, 1);
        idle(6000);
        check("thresh_err_sticky", er[0], 1);
        check_drained("thresh");

        // full frame of 52 pixels
        for (int i = 0; i < 52; i++) begin
            w = {8'(i), ~8'(i), 8'(i)};
            expect_px(1, 6'(i), w);
            send_bits(1, w, 23, 0);
        end
        expect_frame(1, 52);
        idle(GAP_F);
        check("frame_err", er[1], 0);
        check_drained("frame");

        // partial pixel then latch gap
        send_bits(1, 24'hFFC000, 23, 14);
        expect_frame(1, 0);
        idle(GAP_F);
        check("partial_err", er[1], 1);
        check_drained("partial");

        // glitch between bits leaves the bit count untouched
        rst_v[1] = 1'b1;
        idle(2);
        rst_v[1] = 1'b0;
        check("glitch_err_after_rst", er[1], 0);
        idle(GAP_F);
        expect_px(1, 0, 24'h3C96E1);
        send_bits(1, 24'h3C96E1, 23, 12);
        pulse(1, 2, 4);
        check("glitch_err", er[1], 1);
        send_bits(1, 24'h3C96E1, 11, 0);
        expect_frame(1, 1);
        idle(GAP_F);
        check_drained("glitch");

        // reset mid-frame: nothing decodes until a full gap has been seen
        send_bits(1, 24'hABCDEF, 23, 12);
        rst_v[1] = 1'b1;
        idle(1);
        rst_v[1] = 1'b0;
        send_bits(1, 24'hDEAD01, 23, 0);
        idle(GAP_F);
        check("rstmid_err", er[1], 0);
        expect_px(1, 0, 24'h0F1E2D);
        send_bits(1, 24'h0F1E2D, 23, 0);
        expect_frame(1, 1);
        idle(GAP_F);
        check_drained("rstmid");

        // pixel index saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            w = 24'h111111 * 24'(i + 1);
            expect_px(2, (i < 3) ? 6'(i) : 6'd3, w);
            send_bits(2, w, 23, 0);
        end
        expect_frame(2, 3);
        idle(GAP_F);
        check("sat_err", er[2], 1);
        check_drained("sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Decodes a WS2812 one-wire serial stream back into 24-bit pixel words.
- It is the receiving end of the strip protocol produced by neopixel_controller.
- Uses: loopback self-check of the POV output path on hardware, and sniffing a chained strip segment.
- Sits beside the strip driver: its input taps ws2812_dout (or a pin), and its outputs feed a checker or a debug register bank.

Parameters:
- T_MIN_HIGH, 20: high pulses shorter than this many clk cycles are glitches (error).
- T_THRESH, 60: a high time of at least this many cycles decodes as 1; below it decodes as 0.
- T_MAX_HIGH, 100: a high time above this is an error (stuck-high).
- T_RESET, 5000: a low time of at least this many cycles is the latch/reset gap, ending the frame (50 us at 100 MHz).
- PX_COUNT_WIDTH, 6: width of the pixel index and frame length.
- BITS_PER_PIXEL, 24: bits per pixel word.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- din  in  1  raw WS2812 line, asynchronous to clk
- pixel_data  out  BITS_PER_PIXEL  last complete pixel; first-received bit in the MSB, wire order (GRB) preserved
- pixel_valid  out  1  one-cycle pulse when pixel_data and pixel_index update
- pixel_index  out  PX_COUNT_WIDTH  position of the pixel within the current frame, 0-based
- frame_done  out  1  one-cycle pulse at the latch gap ending a frame
- frame_len  out  PX_COUNT_WIDTH  complete pixels in the last frame, valid with frame_done and held after it
- err  out  1  sticky error flag, cleared only by rst

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM state is ARM; all counters and the shift register are 0.
- Input path:
  - din passes through a 2-flop synchronizer, then a registered copy for edge detection.
  - All timing is measured on the synchronized signal.
  - Latency from a din edge to the FSM seeing it: 2 cycles.
- Timer:
  - One counter of $clog2(T_RESET+1) bits; saturates at T_RESET and never wraps.
  - Cleared on every synchronized edge.
- States:
  - ARM: waits for T_RESET consecutive low cycles, so the receiver never decodes mid-frame after reset. Then goes to GAP with bit_cnt = 0 and px_cnt = 0.
  - GAP (line low): a rising edge goes to HIGH. If the timer reaches T_RESET, the frame ends (see frame-end rules) and the state stays GAP.
  - HIGH (line high): on the falling edge, classify the high time h.
    - h < T_MIN_HIGH: set err and discard the bit; next state GAP.
    - T_MIN_HIGH ≤ h < T_THRESH: shift 0 in.
    - T_THRESH ≤ h ≤ T_MAX_HIGH: shift 1 in.
    - After a valid bit: bit_cnt++, next state GAP.
    - If the timer exceeds T_MAX_HIGH while still high: set err and go to ERR.
  - ERR: waits for the line to go low, then T_RESET low cycles. Then goes to GAP with bit_cnt = 0 and px_cnt = 0, without pulsing frame_done.
- Pixel completion, on the cycle the 24th bit is shifted in:
  - The next cycle outputs pixel_data = the shifted word, pixel_index = px_cnt, and pixel_valid = 1 for one cycle.
  - bit_cnt then goes to 0 and px_cnt increments.
- px_cnt saturation:
  - px_cnt saturates at 2^PX_COUNT_WIDTH−1; further pixels still pulse pixel_valid at that index.
  - A pixel arriving once px_cnt is already saturated sets err.
- Frame end, when the GAP timer reaches T_RESET:
  - If px_cnt > 0 or bit_cnt > 0: pulse frame_done for one cycle, with frame_len = px_cnt.
  - If bit_cnt ≠ 0 (a partial pixel): set err and discard the partial bits.
  - Then clear px_cnt and bit_cnt.
  - An idle line with no bits received produces no frame_done pulse.
  - The timer holds saturated, so only one pulse occurs per gap.
- Low time between bits: any length below T_RESET is accepted; there is no minimum low-time check.
- Simultaneous events: frame end and a rising edge cannot coincide, because a rising edge clears the timer first and takes priority.
- rst asserted mid-frame: returns to ARM immediately and asynchronously. Any partially received pixel is never output.

Decomposition:
- Package ws2812_pkg holds:
  - state enum: ARM, GAP, HIGH, ERR.
  - Default timing constants, shared with the transmit side: T0H = 40, T1H = 80, bit period = 125, T_RESET = 5000 cycles at 100 MHz.
  - Width function for the timer.
- One sub-module is natural: ws2812_sync_edge, the 2-flop synchronizer plus rise/fall detect. It is reusable, since breakbeam_sync_debounce has the same front end.

Test Plan:
- Single pixel:
  - Stimulus: 6000 cycles low, then the 24 bits of 0xA5C33C (0 = 40 high/85 low, 1 = 80 high/45 low), then 6000 cycles low.
  - Required: one pixel_valid with pixel_data = 0xA5C33C, pixel_index = 0; then frame_done with frame_len = 1; err = 0.
- Full frame:
  - Stimulus: 52 pixels with pixel i = {i, ~i, i} (8-bit fields), then the latch gap.
  - Required: 52 pixel_valid pulses with the matching data and indices 0..51; frame_done with frame_len = 52.
- Threshold edges:
  - Stimulus: high times of 59, 60, 100, then 101 cycles.
  - Required: 59 decodes as 0; 60 and 100 decode as 1; 101 sets err and enters ERR. After 5000 low cycles the receiver returns to GAP and the next clean pixel decodes correctly.
- Partial pixel and glitch:
  - Partial pixel: 10 bits then the latch gap → frame_done with frame_len = 0, err = 1, no pixel_valid.
  - Glitch (separate run after rst): a 10-cycle high pulse → err = 1 and bit_cnt unchanged.
- Reset mid-frame / ARM:
  - Stimulus: rst asserted after 12 bits, released, then bits restart with no gap.
  - Required: no outputs until 5000 low cycles have passed; the first frame after that decodes from index 0.
- px_cnt saturation:
  - Stimulus: PX_COUNT_WIDTH = 2, 5 pixels in one frame.
  - Required: pixel_index sequence 0, 1, 2, 3, 3; err = 1; frame_len = 3.
